// File: rtl/gmii_pkg.sv
// Shared GMII framing constants, FSM state encoding and the byte-serial CRC-32 step.
package gmii_pkg;

  localparam logic [7:0]  GMII_PRE      = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SFD   = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAD   = 3'd4,
    ST_FCS   = 3'd5,
    ST_DRAIN = 3'd6,
    ST_IFG   = 3'd7
  } gmii_state_e;

  // Ethernet sends bits LSB-first, so the shift register runs on the reflected polynomial.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] rpoly;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) begin
      rpoly[i] = CRC32_POLY[31 - i];
    end
    c = crc ^ {24'h000000, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ rpoly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Source-side frame byte handshake (srdy/drdy) between a frame source and the framer.
interface gmii_tx_framer_if;
  logic       c_srdy;
  logic       c_drdy;
  logic [7:0] c_data;
  logic       c_eop;

  modport master (output c_srdy, output c_data, output c_eop, input c_drdy);
  modport slave  (input c_srdy, input c_data, input c_eop, output c_drdy);
endinterface

// File: rtl/gmii_crc32.sv
// Byte-serial CRC-32 register: init reloads all-ones, en folds one byte in.
module gmii_crc32
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: reload, update or hold.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC32_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, padding, underrun handling, IFG.
// Define GMII_TX_CRC_EN to generate and append the FCS in hardware.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int PRE_LEN   = 7,
  parameter int IFG_LEN   = 12,
  parameter int MIN_FRAME = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  gmii_tx_framer_if.slave c,
  output logic [7:0]      gmii_txd,
  output logic            gmii_tx_en,
  output logic            gmii_tx_er,
  output logic            underrun
);

`ifdef GMII_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  // Payload length target excludes the FCS when the framer appends it itself.
  localparam logic [10:0] PAD_TARGET = CRC_ON ? 11'(MIN_FRAME - 4) : 11'(MIN_FRAME);
  localparam gmii_state_e POST_ST    = CRC_ON ? ST_FCS : ST_IFG;
  localparam logic [7:0]  POST_CNT   = CRC_ON ? 8'd0 : 8'd1;

  gmii_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d, byte_inc_s;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d, er_q, er_d, urun_q, urun_d;
  logic        byte_en_s;
  logic [31:0] fcs_s;

`ifdef GMII_TX_CRC_EN
  logic [31:0] crc_s;
  gmii_crc32 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init_i  (state_q == ST_IDLE),
    .en_i    (byte_en_s),
    .data_i  (txd_d),
    .crc_o   (crc_s)
  );
  assign fcs_s = ~crc_s;
`else
  assign fcs_s = 32'h00000000;
`endif

  assign c.c_drdy   = (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign byte_inc_s = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : (byte_cnt_q + 11'd1);
  assign byte_cnt_d = (state_q == ST_IDLE) ? 11'd0 : (byte_en_s ? byte_inc_s : byte_cnt_q);

  // Next state and the byte to present on GMII in the following cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    txd_d     = 8'h00;
    en_d      = 1'b0;
    er_d      = 1'b0;
    urun_d    = 1'b0;
    byte_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (c.c_srdy) begin
          txd_d   = GMII_PRE;
          en_d    = 1'b1;
          cnt_d   = 8'd1;
          state_d = (PRE_LEN == 1) ? ST_SFD : ST_PRE;
        end else begin
          cnt_d = 8'd0;
        end
      end
      ST_PRE: begin
        txd_d = GMII_PRE;
        en_d  = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(PRE_LEN - 1)) begin
          state_d = ST_SFD;
        end else begin
          state_d = ST_PRE;
        end
      end
      ST_SFD: begin
        txd_d   = GMII_SFD;
        en_d    = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        en_d = 1'b1;
        if (c.c_srdy) begin
          txd_d     = c.c_data;
          byte_en_s = 1'b1;
          if (!c.c_eop) begin
            state_d = ST_DATA;
          end else if (byte_inc_s < PAD_TARGET) begin
            state_d = ST_PAD;
          end else begin
            state_d = POST_ST;
            cnt_d   = POST_CNT;
          end
        end else begin
          er_d    = 1'b1;
          urun_d  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_PAD: begin
        en_d      = 1'b1;
        byte_en_s = 1'b1;
        if (byte_inc_s >= PAD_TARGET) begin
          state_d = POST_ST;
          cnt_d   = POST_CNT;
        end else begin
          state_d = ST_PAD;
        end
      end
      ST_FCS: begin
        en_d  = 1'b1;
        cnt_d = cnt_q + 8'd1;
        case (cnt_q[1:0])
          2'd0:    txd_d = fcs_s[7:0];
          2'd1:    txd_d = fcs_s[15:8];
          2'd2:    txd_d = fcs_s[23:16];
          default: txd_d = fcs_s[31:24];
        endcase
        if (cnt_q[1:0] == 2'd3) begin
          state_d = ST_IFG;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_FCS;
        end
      end
      ST_DRAIN: begin
        if (c.c_srdy && c.c_eop) begin
          state_d = ST_IFG;
          cnt_d   = 8'd1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_IFG: begin
        if (cnt_q == 8'(IFG_LEN)) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // FSM, counters and registered GMII outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 11'd0;
      txd_q      <= 8'h00;
      en_q       <= 1'b0;
      er_q       <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      txd_q      <= txd_d;
      en_q       <= en_d;
      er_q       <= er_d;
      urun_q     <= urun_d;
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;
  assign underrun   = urun_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Table-driven scoreboard bench for gmii_tx_framer (works with or without GMII_TX_CRC_EN).
module tb_gmii_tx_framer;

  localparam int PRE_LEN   = 7;
  localparam int IFG_LEN   = 12;
  localparam int MIN_FRAME = 64;
  localparam int NV        = 7;
`ifdef GMII_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef struct { logic [7:0] txd; logic er; logic ur; } wire_t;
  typedef struct { int len; int drop; int after_on; int after_off; int gap; } vec_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       underrun;

  gmii_tx_framer_if cif();

  gmii_tx_framer #(.PRE_LEN(PRE_LEN), .IFG_LEN(IFG_LEN), .MIN_FRAME(MIN_FRAME)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .c          (cif),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .underrun   (underrun)
  );

  wire_t       exp_q[$];
  int          len_q[$];
  int          gap_q[$];
  logic [31:0] res_q[$];
  logic [7:0]  fbuf[128];
  vec_t        tbl[NV];
  int          total;
  int          bad;
  bit          mon_on;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
  endtask

  // Expected wire image of one frame.
  task automatic push_expect(input int len, input int drop);
    logic [31:0] c;
    int          target;
    wire_t       w;
    for (int i = 0; i < PRE_LEN; i++) begin
      w = '{8'h55, 1'b0, 1'b0};
      exp_q.push_back(w);
    end
    w = '{8'hD5, 1'b0, 1'b0};
    exp_q.push_back(w);
    if (drop > 0) begin
      for (int i = 0; i < drop; i++) begin
        w = '{fbuf[i], 1'b0, 1'b0};
        exp_q.push_back(w);
      end
      w = '{8'h00, 1'b1, 1'b1};
      exp_q.push_back(w);
    end else begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len; i++) begin
        w = '{fbuf[i], 1'b0, 1'b0};
        exp_q.push_back(w);
        c = crc_ref(c, fbuf[i]);
      end
      target = CRC_ON ? MIN_FRAME - 4 : MIN_FRAME;
      for (int n = len; n < target; n++) begin
        w = '{8'h00, 1'b0, 1'b0};
        exp_q.push_back(w);
        c = crc_ref(c, 8'h00);
      end
`ifdef GMII_TX_CRC_EN
      c = ~c;
      for (int k = 0; k < 4; k++) begin
        w = '{c[8*k +: 8], 1'b0, 1'b0};
        exp_q.push_back(w);
      end
`endif
    end
  endtask

  // Source driver; optionally drops srdy for one cycle or asserts reset mid-frame.
  task automatic drive_frame(input int len, input int drop_at, input int rst_at, output int first_wait);
    int sent;
    int waited;
    bit dropped;
    sent = 0; waited = 0; dropped = 1'b0; first_wait = -1;
    while (sent < len) begin
      cif.c_srdy = 1'b1;
      cif.c_data = fbuf[sent];
      cif.c_eop  = (sent == len - 1);
      @(negedge clk);
      if (cif.c_drdy) begin
        if (first_wait < 0) first_wait = waited;
        waited = 0;
        @(posedge clk); #1;
        sent++;
        if (sent == drop_at && !dropped) begin
          cif.c_srdy = 1'b0;
          dropped    = 1'b1;
          @(posedge clk); #1;
        end
        if (rst_at > 0 && sent == rst_at) begin
          chk("en_before_reset", 64'(gmii_tx_en), 64'd1);
          #1 reset_n = 1'b0;
          break;
        end
      end else begin
        waited++;
        if (waited > 2000) begin
          chk("drdy_timeout", 64'(waited), 64'd0);
          break;
        end
        @(posedge clk); #1;
      end
    end
    cif.c_srdy = 1'b0;
    cif.c_eop  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 5000; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (IFG_LEN + 4) @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pops on tx_en, idle checks otherwise, frame length/gap/residue capture.
  initial begin
    wire_t       e;
    bit          prev_en;
    bit          have_fall;
    int          nbytes;
    int          gap;
    logic [31:0] mcrc;
    prev_en = 1'b0; have_fall = 1'b0; nbytes = 0; gap = 0; mcrc = 32'hFFFFFFFF;
    forever begin
      @(negedge clk);
      if (!mon_on || !reset_n) begin
        prev_en = 1'b0; have_fall = 1'b0; nbytes = 0; gap = 0; mcrc = 32'hFFFFFFFF;
      end else begin
        if (gmii_tx_en) begin
          if (!prev_en && have_fall) gap_q.push_back(gap);
          chk("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wire_byte", 64'({gmii_tx_er, underrun, gmii_txd}), 64'({e.er, e.ur, e.txd}));
          end
          if (nbytes > PRE_LEN) mcrc = crc_ref(mcrc, gmii_txd);
          nbytes++;
        end else begin
          chk("idle_out", 64'({gmii_tx_er, underrun, gmii_txd}), 64'd0);
          if (prev_en) begin
            len_q.push_back(nbytes - PRE_LEN - 1);
            res_q.push_back(mcrc);
            nbytes = 0; mcrc = 32'hFFFFFFFF; have_fall = 1'b1; gap = 1;
          end else begin
            gap++;
          end
        end
        prev_en = gmii_tx_en;
      end
    end
  end

  initial begin
    int fw;
    total = 0; bad = 0; mon_on = 1'b0;
    reset_n = 1'b0; cif.c_srdy = 1'b0; cif.c_data = 8'h00; cif.c_eop = 1'b0;

    tbl[0] = '{64,  0, 68, 64, 12};
    tbl[1] = '{10,  0, 64, 64, 12};
    tbl[2] = '{1,   0, 64, 64, 12};
    tbl[3] = '{100, 20, 21, 21, 92};
    tbl[4] = '{60,  0, 64, 64, 12};
    tbl[5] = '{59,  0, 64, 64, 12};
    tbl[6] = '{70,  0, 74, 70, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({gmii_tx_en, gmii_tx_er, underrun, gmii_txd, cif.c_drdy}), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;

    for (int i = 0; i < NV; i++) begin
      fill(tbl[i].len);
      push_expect(tbl[i].len, tbl[i].drop);
      drive_frame(tbl[i].len, tbl[i].drop, 0, fw);
      if (i == 0) chk("first_drdy_wait", 64'(fw), 64'(PRE_LEN + 1));
    end
    wait_drain();

    chk("frame_count", 64'(len_q.size()), 64'(NV));
    chk("gap_count", 64'(gap_q.size()), 64'(NV - 1));
    for (int i = 0; i < NV; i++) begin
      if (len_q.size() != 0) chk("after_sfd_len", 64'(len_q.pop_front()), 64'(CRC_ON ? tbl[i].after_on : tbl[i].after_off));
      if (i < NV - 1 && gap_q.size() != 0) chk("ifg_gap", 64'(gap_q.pop_front()), 64'(tbl[i].gap));
`ifdef GMII_TX_CRC_EN
      if (res_q.size() != 0) begin
        logic [31:0] r;
        r = res_q.pop_front();
        if (tbl[i].drop == 0) chk("fcs_residue", 64'(r), 64'h00000000C704DD7B);
      end
`endif
    end

    // Reset in the middle of a frame, then a fresh frame after release.
    mon_on = 1'b0;
    fill(64);
    drive_frame(64, 0, 30, fw);
    #1;
    chk("async_reset_outputs", 64'({gmii_tx_en, gmii_tx_er, underrun, gmii_txd, cif.c_drdy}), 64'd0);
    exp_q.delete(); len_q.delete(); gap_q.delete(); res_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;
    fill(10);
    push_expect(10, 0);
    drive_frame(10, 0, 0, fw);
    chk("first_drdy_after_reset", 64'(fw), 64'(PRE_LEN + 1));
    wait_drain();
    chk("post_reset_count", 64'(len_q.size()), 64'd1);
    if (len_q.size() != 0) chk("post_reset_len", 64'(len_q.pop_front()), 64'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
